// File: rtl/jls_neighbor_window_if.sv
// Pixel-in / causal-window-out bus for the JPEG-LS neighbour window stage.
// Latency: n/a (bundle of wires). Backpressure: none; the stream is strobe-only.
// Signals: width_m1/height_m1 frame config, ivalid/idata raster input,
//          ovalid + ox/oa/ob/oc/od window and position flags output.
interface jls_neighbor_window_if #(
  parameter int WLEVEL = 12,
  parameter int HLEVEL = 16,
  parameter int DWIDTH = 8
);
  logic [WLEVEL-1:0] width_m1;
  logic [HLEVEL-1:0] height_m1;
  logic              ivalid;
  logic [DWIDTH-1:0] idata;
  logic              ovalid;
  logic [DWIDTH-1:0] ox;
  logic [DWIDTH-1:0] oa;
  logic [DWIDTH-1:0] ob;
  logic [DWIDTH-1:0] oc;
  logic [DWIDTH-1:0] od;
  logic              ocol_first;
  logic              ocol_last;
  logic              orow_first;
  logic              oeof;

  // Source side: drives config and pixels, receives windows.
  modport master (
    output width_m1, height_m1, ivalid, idata,
    input  ovalid, ox, oa, ob, oc, od, ocol_first, ocol_last, orow_first, oeof
  );

  // Window block side.
  modport slave (
    input  width_m1, height_m1, ivalid, idata,
    output ovalid, ox, oa, ob, oc, od, ocol_first, ocol_last, orow_first, oeof
  );
endinterface

// File: rtl/jls_neighbor_window.sv
// shift_buffer: programmable one-row delay line (circular RAM, length len_i+1).
// Latency: delayed sample on dout_o the cycle after en_i, held until next en_i.
// Backpressure: none; advances only on en_i.
// Ports: clk, rst (sync, active high), en_i, len_i (row length - 1), din_i, dout_o.
module shift_buffer #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [AWIDTH-1:0] len_i,
  input  logic [DWIDTH-1:0] din_i,
  output logic [DWIDTH-1:0] dout_o
);
  logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic [DWIDTH-1:0] dout_q;

  assign ptr_d  = (ptr_q == len_i) ? '0 : ptr_q + AWIDTH'(1);
  assign dout_o = dout_q;

  // Read-before-write at the same slot yields the sample from one row ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      dout_q <= '0;
    end else if (en_i) begin
      ptr_q  <= ptr_d;
      dout_q <= mem[ptr_q];
    end
  end

  // Storage is not reset: stale contents are masked downstream on row 0.
  always_ff @(posedge clk) begin
    if (en_i) mem[ptr_q] <= din_i;
  end
endmodule

// jls_neighbor_window: JPEG-LS causal window (x,a,b,c,d) with edge rules per pixel.
// Latency: window of pixel p-1 two cycles after pixel p arrives (col>0);
//          last-column pixel emits its own window three cycles after arrival.
// Backpressure: none; emission timing depends only on arrival cycles.
// Ports: clk, rst (sync, active high), bus (slave modport: config, pixels in, window out).
module jls_neighbor_window #(
  parameter int WLEVEL = 12,
  parameter int HLEVEL = 16,
  parameter int DWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  jls_neighbor_window_if.slave bus
);
  typedef struct packed {
    logic col_first;
    logic col_last;
    logic row_first;
    logic eof;
  } meta_t;

  // Position and latched frame geometry.
  logic [WLEVEL-1:0] col_q, col_d;
  logic [HLEVEL-1:0] row_q, row_d;
  logic [WLEVEL-1:0] width_q, width_d;
  logic [HLEVEL-1:0] height_q, height_d;
  logic              frame_start;
  logic [WLEVEL-1:0] eff_w;
  logic [HLEVEL-1:0] eff_h;
  meta_t             in_meta;

  // Pixel history: cur = p, prv = p-1, prv2 = p-2; u1/u2 = line buffer for p-1, p-2.
  logic [DWIDTH-1:0] cur_x_q, prv_x_q, prv2_x_q;
  meta_t             cur_meta_q, prv_meta_q;
  logic [DWIDTH-1:0] u1_q, u2_q;
  logic [DWIDTH-1:0] sb_dout;

  // Emission control.
  logic              emit_q;      // previous-pixel window due this cycle
  logic              flcap_q;     // last-column pixel arrived last cycle: snapshot it
  logic              fl_vld_q;    // flush-slot window due this cycle
  logic [DWIDTH-1:0] fl_x_q, fl_a_q, fl_b_q, fl_c_q;
  meta_t             fl_meta_q;
  logic [DWIDTH-1:0] saved_b_q;   // b of the most recent column-0 pixel

  // Window selected this cycle.
  logic              win_vld;
  logic [DWIDTH-1:0] win_x, win_a, win_b, win_c, win_d;
  meta_t             win_meta;

  // Registered outputs.
  logic              ovalid_q;
  logic [DWIDTH-1:0] ox_q, oa_q, ob_q, oc_q, od_q;
  meta_t             ometa_q;

  // Geometry used for the arriving pixel: the live config on (0,0), latched after.
  assign frame_start = (col_q == '0) && (row_q == '0);
  assign eff_w       = frame_start ? bus.width_m1  : width_q;
  assign eff_h       = frame_start ? bus.height_m1 : height_q;

  always_comb begin
    in_meta           = '0;
    in_meta.col_first = (col_q == '0);
    in_meta.col_last  = (col_q == eff_w);
    in_meta.row_first = (row_q == '0);
    in_meta.eof       = (col_q == eff_w) && (row_q == eff_h);
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    width_d  = width_q;
    height_d = height_q;
    if (bus.ivalid) begin
      if (frame_start) begin
        width_d  = bus.width_m1;
        height_d = bus.height_m1;
      end
      if (col_q == eff_w) begin
        col_d = '0;
        row_d = (row_q == eff_h) ? '0 : row_q + HLEVEL'(1);
      end else begin
        col_d = col_q + WLEVEL'(1);
      end
    end
  end

  shift_buffer #(
    .AWIDTH (WLEVEL),
    .DWIDTH (DWIDTH)
  ) u_line (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.ivalid),
    .len_i  (eff_w),
    .din_i  (bus.idata),
    .dout_o (sb_dout)
  );

  // The two emission sources never overlap: the arrival after a last-column
  // pixel is column 0, which schedules nothing.
  always_comb begin
    win_vld  = 1'b0;
    win_x    = '0;
    win_a    = '0;
    win_b    = '0;
    win_c    = '0;
    win_d    = '0;
    win_meta = '0;
    if (fl_vld_q) begin
      win_vld  = 1'b1;
      win_meta = fl_meta_q;
      win_x    = fl_x_q;
      win_a    = fl_a_q;
      if (!fl_meta_q.row_first) begin
        win_b = fl_b_q;
        win_c = fl_c_q;
        win_d = fl_b_q;
      end
    end else if (emit_q) begin
      // Window of p-1; sb_dout now holds the above sample of p (right neighbour).
      win_vld  = 1'b1;
      win_meta = prv_meta_q;
      win_x    = prv_x_q;
      if (prv_meta_q.row_first) begin
        win_a = prv_meta_q.col_first ? '0 : prv2_x_q;
      end else if (prv_meta_q.col_first) begin
        win_a = u1_q;
        win_b = u1_q;
        win_c = saved_b_q;
        win_d = sb_dout;
      end else begin
        win_a = prv2_x_q;
        win_b = u1_q;
        win_c = u2_q;
        win_d = sb_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      width_q    <= '0;
      height_q   <= '0;
      cur_x_q    <= '0;
      prv_x_q    <= '0;
      prv2_x_q   <= '0;
      cur_meta_q <= '0;
      prv_meta_q <= '0;
      u1_q       <= '0;
      u2_q       <= '0;
      emit_q     <= 1'b0;
      flcap_q    <= 1'b0;
      fl_vld_q   <= 1'b0;
      fl_x_q     <= '0;
      fl_a_q     <= '0;
      fl_b_q     <= '0;
      fl_c_q     <= '0;
      fl_meta_q  <= '0;
      saved_b_q  <= '0;
      ovalid_q   <= 1'b0;
      ox_q       <= '0;
      oa_q       <= '0;
      ob_q       <= '0;
      oc_q       <= '0;
      od_q       <= '0;
      ometa_q    <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      width_q  <= width_d;
      height_q <= height_d;

      emit_q  <= bus.ivalid && !in_meta.col_first;
      flcap_q <= bus.ivalid && in_meta.col_last;

      if (bus.ivalid) begin
        cur_x_q    <= bus.idata;
        prv_x_q    <= cur_x_q;
        prv2_x_q   <= prv_x_q;
        cur_meta_q <= in_meta;
        prv_meta_q <= cur_meta_q;
        u1_q       <= sb_dout;  // line buffer output still belongs to p-1 here
        u2_q       <= u1_q;
      end

      // Snapshot the last-column pixel before a following arrival shifts history.
      fl_vld_q <= flcap_q;
      if (flcap_q) begin
        fl_x_q    <= cur_x_q;
        fl_a_q    <= prv_x_q;
        fl_b_q    <= sb_dout;
        fl_c_q    <= u1_q;
        fl_meta_q <= cur_meta_q;
      end

      ovalid_q <= win_vld;
      if (win_vld) begin
        ox_q    <= win_x;
        oa_q    <= win_a;
        ob_q    <= win_b;
        oc_q    <= win_c;
        od_q    <= win_d;
        ometa_q <= win_meta;
        if (win_meta.col_first) saved_b_q <= win_b;
      end
    end
  end

  assign bus.ovalid     = ovalid_q;
  assign bus.ox         = ox_q;
  assign bus.oa         = oa_q;
  assign bus.ob         = ob_q;
  assign bus.oc         = oc_q;
  assign bus.od         = od_q;
  assign bus.ocol_first = ometa_q.col_first;
  assign bus.ocol_last  = ometa_q.col_last;
  assign bus.orow_first = ometa_q.row_first;
  assign bus.oeof       = ometa_q.eof;
endmodule
